// File: rtl/sel_max_pkg.sv
// Shared types and default sizing for the streaming max/min selector.
// Optional argmax datapath is controlled by macro SEL_MAX_ARGMAX_EN.
package sel_max_pkg;

  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_MIN = 1'b1
  } mode_e;

  localparam int DEF_D_W = 16;
  localparam int DEF_N   = 16;

endpackage

// File: rtl/sel_max_cell.sv
// Combinational compare-select of two (value, index) pairs; a is always the lower-index side.
// Index ports exist only when macro SEL_MAX_ARGMAX_EN is defined.
module sel_max_cell
  import sel_max_pkg::*;
#(
  parameter int D_W = DEF_D_W
`ifdef SEL_MAX_ARGMAX_EN
  ,
  parameter int IW  = $clog2(DEF_N)
`endif
) (
  input  mode_e          mode,
  input  logic [D_W-1:0] a_val,
  input  logic [D_W-1:0] b_val,
`ifdef SEL_MAX_ARGMAX_EN
  input  logic [IW-1:0]  a_idx,
  input  logic [IW-1:0]  b_idx,
  output logic [IW-1:0]  y_idx,
`endif
  output logic [D_W-1:0] y_val
);

  logic b_wins_s;

  // b replaces a only when strictly better, so ties keep the lower index
  always_comb begin
    b_wins_s = 1'b0;
    case (mode)
      MODE_MAX: b_wins_s = ($signed(b_val) > $signed(a_val));
      MODE_MIN: b_wins_s = ($signed(b_val) < $signed(a_val));
      default:  b_wins_s = 1'b0;
    endcase
  end

  // select the winning pair
  always_comb begin
    y_val = a_val;
`ifdef SEL_MAX_ARGMAX_EN
    y_idx = a_idx;
`endif
    if (b_wins_s) begin
      y_val = b_val;
`ifdef SEL_MAX_ARGMAX_EN
      y_idx = b_idx;
`endif
    end else begin
      y_val = a_val;
`ifdef SEL_MAX_ARGMAX_EN
      y_idx = a_idx;
`endif
    end
  end

endmodule

// File: rtl/sel_max_stream.sv
// Fully pipelined log2(N)-level signed max/min reduction tree with valid/ready flow control.
// Macro SEL_MAX_ARGMAX_EN adds the winning-index datapath and the O_IDX port.
module sel_max_stream
  import sel_max_pkg::*;
#(
  parameter int D_W = DEF_D_W,
  parameter int N   = DEF_N
) (
  input  logic           I_CLK,
  input  logic           I_RST,
  input  logic           I_VLD,
  output logic           O_RDY,
  input  logic           I_MODE,
  input  logic [D_W-1:0] I_DATA [0:N-1],
  output logic           O_VLD,
  input  logic           I_RDY,
`ifdef SEL_MAX_ARGMAX_EN
  output logic [$clog2(N)-1:0] O_IDX,
`endif
  output logic [D_W-1:0] O_MAX
);

  localparam int L     = $clog2(N);
  localparam int NODES = N - 1;
`ifdef SEL_MAX_ARGMAX_EN
  localparam int IW    = $clog2(N);
`endif

  // Tree nodes are stored level by level: level l starts at N - (N >> l).
  logic           en_s;
  logic [D_W-1:0] val_s     [NODES];
  logic [D_W-1:0] val_r     [NODES];
  logic           vld_r     [L];
  mode_e          mode_r    [L];
  mode_e          mode_in_s [L];
`ifdef SEL_MAX_ARGMAX_EN
  logic [IW-1:0]  idx_s     [NODES];
  logic [IW-1:0]  idx_r     [NODES];
`endif

  assign en_s  = I_RST | ~vld_r[L-1] | I_RDY;
  assign O_RDY = en_s;
  assign O_VLD = vld_r[L-1];
  assign O_MAX = val_r[NODES-1];
`ifdef SEL_MAX_ARGMAX_EN
  assign O_IDX = idx_r[NODES-1];
`endif

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int OFF = N - (N >> l);

    if (l == 0) begin : g_src
      assign mode_in_s[l] = mode_e'(I_MODE);
    end else begin : g_src
      assign mode_in_s[l] = mode_r[l-1];
    end

    for (genvar c = 0; c < (N >> (l + 1)); c++) begin : g_node
      logic [D_W-1:0] a_val_s;
      logic [D_W-1:0] b_val_s;
`ifdef SEL_MAX_ARGMAX_EN
      logic [IW-1:0]  a_idx_s;
      logic [IW-1:0]  b_idx_s;
`endif

      if (l == 0) begin : g_leaf
        assign a_val_s = I_DATA[2*c];
        assign b_val_s = I_DATA[2*c+1];
`ifdef SEL_MAX_ARGMAX_EN
        assign a_idx_s = IW'(2*c);
        assign b_idx_s = IW'(2*c+1);
`endif
      end else begin : g_inner
        localparam int PRV = N - (N >> (l - 1));
        assign a_val_s = val_r[PRV + 2*c];
        assign b_val_s = val_r[PRV + 2*c + 1];
`ifdef SEL_MAX_ARGMAX_EN
        assign a_idx_s = idx_r[PRV + 2*c];
        assign b_idx_s = idx_r[PRV + 2*c + 1];
`endif
      end

`ifdef SEL_MAX_ARGMAX_EN
      sel_max_cell #(.D_W(D_W), .IW(IW)) u_cell (
        .mode  (mode_in_s[l]),
        .a_val (a_val_s),
        .b_val (b_val_s),
        .a_idx (a_idx_s),
        .b_idx (b_idx_s),
        .y_idx (idx_s[OFF + c]),
        .y_val (val_s[OFF + c])
      );
`else
      sel_max_cell #(.D_W(D_W)) u_cell (
        .mode  (mode_in_s[l]),
        .a_val (a_val_s),
        .b_val (b_val_s),
        .y_val (val_s[OFF + c])
      );
`endif
    end
  end

  // pipeline registers: all stages advance together on en_s
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      for (int i = 0; i < L; i++) begin
        vld_r[i]  <= 1'b0;
        mode_r[i] <= MODE_MAX;
      end
      for (int n = 0; n < NODES; n++) begin
        val_r[n] <= {D_W{1'b0}};
`ifdef SEL_MAX_ARGMAX_EN
        idx_r[n] <= {IW{1'b0}};
`endif
      end
    end else if (en_s) begin
      vld_r[0] <= I_VLD;
      for (int i = 1; i < L; i++) begin
        vld_r[i] <= vld_r[i-1];
      end
      for (int i = 0; i < L; i++) begin
        mode_r[i] <= mode_in_s[i];
      end
      for (int n = 0; n < NODES; n++) begin
        val_r[n] <= val_s[n];
`ifdef SEL_MAX_ARGMAX_EN
        idx_r[n] <= idx_s[n];
`endif
      end
    end
  end

endmodule

// File: tb/tb_sel_max_stream.sv
// Directed self-checking bench for sel_max_stream (N=16 main instance, N=4 secondary).
// Index checks are compiled in only with macro SEL_MAX_ARGMAX_EN.
module tb_sel_max_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic        mode;
  logic        rdy;
  logic [15:0] data [0:15];
  logic        o_rdy;
  logic        o_vld;
  logic [15:0] o_max;
`ifdef SEL_MAX_ARGMAX_EN
  logic [3:0]  o_idx;
  logic [1:0]  o_idx4;
`endif

  logic        vld4;
  logic [15:0] data4 [0:3];
  logic        o_rdy4;
  logic        o_vld4;
  logic [15:0] o_max4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sel_max_stream #(.D_W(16), .N(16)) u_dut (
    .I_CLK  (clk),
    .I_RST  (rst),
    .I_VLD  (vld),
    .O_RDY  (o_rdy),
    .I_MODE (mode),
    .I_DATA (data),
    .O_VLD  (o_vld),
    .I_RDY  (rdy),
`ifdef SEL_MAX_ARGMAX_EN
    .O_IDX  (o_idx),
`endif
    .O_MAX  (o_max)
  );

  sel_max_stream #(.D_W(16), .N(4)) u_dut4 (
    .I_CLK  (clk),
    .I_RST  (rst),
    .I_VLD  (vld4),
    .O_RDY  (o_rdy4),
    .I_MODE (mode),
    .I_DATA (data4),
    .O_VLD  (o_vld4),
    .I_RDY  (rdy),
`ifdef SEL_MAX_ARGMAX_EN
    .O_IDX  (o_idx4),
`endif
    .O_MAX  (o_max4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [15:0] fill, input int pos, input logic [15:0] val);
    for (int k = 0; k < 16; k++) data[k] = fill;
    data[pos] = val;
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b0; vld4 = 1'b0; rdy = 1'b1; mode = 1'b0;
    set_vec(16'h0000, 0, 16'h0000);
    for (int k = 0; k < 4; k++) data4[k] = 16'h0000;
    tick(); tick();
    checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL reset_vld: got %b want 0", o_vld); end
    checks++; if (o_max !== 16'h0000) begin failures++; $display("FAIL reset_max: got %h want 0000", o_max); end
    checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy: got %b want 1", o_rdy); end
`ifdef SEL_MAX_ARGMAX_EN
    checks++; if (o_idx !== 4'd0) begin failures++; $display("FAIL reset_idx: got %0d want 0", o_idx); end
`endif
    rst = 1'b0;
    tick();
    checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL post_reset_vld: got %b want 0", o_vld); end
  endtask

  task automatic test_max();
    for (int k = 0; k < 16; k++) data[k] = 16'(k);
    data[7] = 16'h7FFF;
    mode = 1'b0; vld = 1'b1;
    tick();
    vld = 1'b0;
    tick(); tick();
    checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL max_early_vld: got %b want 0", o_vld); end
    tick();
    checks++; if (o_vld !== 1'b1) begin failures++; $display("FAIL max_vld: got %b want 1", o_vld); end
    checks++; if (o_max !== 16'h7FFF) begin failures++; $display("FAIL max_val: got %h want 7fff", o_max); end
`ifdef SEL_MAX_ARGMAX_EN
    checks++; if (o_idx !== 4'd7) begin failures++; $display("FAIL max_idx: got %0d want 7", o_idx); end
`endif
    tick();
    checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL max_drain: got %b want 0", o_vld); end
  endtask

  task automatic test_signed_min_tie();
    set_vec(16'hFFFF, 3, 16'h8000);
    mode = 1'b1; vld = 1'b1;
    tick();
    mode = 1'b0;
    tick();
    vld = 1'b0; mode = 1'b1;
    tick(); tick();
    checks++; if (o_vld !== 1'b1 || o_max !== 16'h8000) begin failures++; $display("FAIL min_val: got vld=%b %h want vld=1 8000", o_vld, o_max); end
`ifdef SEL_MAX_ARGMAX_EN
    checks++; if (o_idx !== 4'd3) begin failures++; $display("FAIL min_idx: got %0d want 3", o_idx); end
`endif
    tick();
    checks++; if (o_vld !== 1'b1 || o_max !== 16'hFFFF) begin failures++; $display("FAIL tie_val: got vld=%b %h want vld=1 ffff", o_vld, o_max); end
`ifdef SEL_MAX_ARGMAX_EN
    checks++; if (o_idx !== 4'd0) begin failures++; $display("FAIL tie_idx: got %0d want 0", o_idx); end
`endif
    tick();
    checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL tie_drain: got %b want 0", o_vld); end
    mode = 1'b0;
  endtask

  task automatic test_back_to_back();
    mode = 1'b0; vld = 1'b1;
    set_vec(16'h0000, 10, 16'd5); tick();
    set_vec(16'h0000, 2, 16'd9);  tick();
    set_vec(16'h0000, 15, 16'd2); tick();
    vld = 1'b0;
    tick();
    rdy = 1'b0; #1;
    checks++; if (o_rdy !== 1'b0) begin failures++; $display("FAIL stall_rdy0: got %b want 0", o_rdy); end
    checks++; if (o_vld !== 1'b1 || o_max !== 16'd5) begin failures++; $display("FAIL stall_first: got vld=%b %h want vld=1 0005", o_vld, o_max); end
`ifdef SEL_MAX_ARGMAX_EN
    checks++; if (o_idx !== 4'd10) begin failures++; $display("FAIL stall_idx: got %0d want 10", o_idx); end
`endif
    tick();
    checks++; if (o_vld !== 1'b1 || o_max !== 16'd5) begin failures++; $display("FAIL stall_hold1: got vld=%b %h want vld=1 0005", o_vld, o_max); end
    checks++; if (o_rdy !== 1'b0) begin failures++; $display("FAIL stall_rdy1: got %b want 0", o_rdy); end
    tick();
    checks++; if (o_vld !== 1'b1 || o_max !== 16'd5) begin failures++; $display("FAIL stall_hold2: got vld=%b %h want vld=1 0005", o_vld, o_max); end
    rdy = 1'b1; #1;
    checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL stall_release_rdy: got %b want 1", o_rdy); end
    tick();
    checks++; if (o_vld !== 1'b1 || o_max !== 16'd9) begin failures++; $display("FAIL order_second: got vld=%b %h want vld=1 0009", o_vld, o_max); end
`ifdef SEL_MAX_ARGMAX_EN
    checks++; if (o_idx !== 4'd2) begin failures++; $display("FAIL order_second_idx: got %0d want 2", o_idx); end
`endif
    tick();
    checks++; if (o_vld !== 1'b1 || o_max !== 16'd2) begin failures++; $display("FAIL order_third: got vld=%b %h want vld=1 0002", o_vld, o_max); end
    tick();
    checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL order_drain: got %b want 0", o_vld); end
  endtask

  task automatic test_bubble();
    mode = 1'b0; vld = 1'b1;
    set_vec(16'h8000, 1, 16'd4); tick();
    vld = 1'b0; tick();
    set_vec(16'h8000, 0, 16'h8000); vld = 1'b1; tick();
    vld = 1'b0;
    tick();
    checks++; if (o_vld !== 1'b1 || o_max !== 16'd4) begin failures++; $display("FAIL bubble_first: got vld=%b %h want vld=1 0004", o_vld, o_max); end
`ifdef SEL_MAX_ARGMAX_EN
    checks++; if (o_idx !== 4'd1) begin failures++; $display("FAIL bubble_first_idx: got %0d want 1", o_idx); end
`endif
    tick();
    checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL bubble_gap: got %b want 0", o_vld); end
    tick();
    checks++; if (o_vld !== 1'b1 || o_max !== 16'h8000) begin failures++; $display("FAIL bubble_second: got vld=%b %h want vld=1 8000", o_vld, o_max); end
`ifdef SEL_MAX_ARGMAX_EN
    checks++; if (o_idx !== 4'd0) begin failures++; $display("FAIL bubble_tie_idx: got %0d want 0", o_idx); end
`endif
    tick();
  endtask

  task automatic test_reset_midflight();
    mode = 1'b0; vld = 1'b1;
    for (int k = 0; k < 16; k++) data[k] = 16'(k);
    tick();
    for (int k = 0; k < 16; k++) data[k] = 16'(15 - k);
    tick();
    vld = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (o_vld !== 1'b0 || o_max !== 16'h0000) begin failures++; $display("FAIL midrst_clear: got vld=%b %h want vld=0 0000", o_vld, o_max); end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (o_vld !== 1'b0) begin failures++; $display("FAIL midrst_ghost: cycle %0d got vld=%b want 0", c, o_vld); end
    end
    set_vec(16'h0000, 4, 16'h0123); vld = 1'b1;
    tick();
    vld = 1'b0;
    tick(); tick(); tick();
    checks++; if (o_vld !== 1'b1 || o_max !== 16'h0123) begin failures++; $display("FAIL midrst_new: got vld=%b %h want vld=1 0123", o_vld, o_max); end
`ifdef SEL_MAX_ARGMAX_EN
    checks++; if (o_idx !== 4'd4) begin failures++; $display("FAIL midrst_new_idx: got %0d want 4", o_idx); end
`endif
    tick();
  endtask

  task automatic test_n4();
    mode = 1'b0;
    data4[0] = 16'hFFFF; data4[1] = 16'h0003; data4[2] = 16'h0003; data4[3] = 16'hFFF8;
    vld4 = 1'b1;
    tick();
    vld4 = 1'b0;
    checks++; if (o_vld4 !== 1'b0) begin failures++; $display("FAIL n4_early: got %b want 0", o_vld4); end
    tick();
    checks++; if (o_vld4 !== 1'b1 || o_max4 !== 16'h0003) begin failures++; $display("FAIL n4_val: got vld=%b %h want vld=1 0003", o_vld4, o_max4); end
`ifdef SEL_MAX_ARGMAX_EN
    checks++; if (o_idx4 !== 2'd1) begin failures++; $display("FAIL n4_idx: got %0d want 1", o_idx4); end
`endif
    tick();
    checks++; if (o_vld4 !== 1'b0) begin failures++; $display("FAIL n4_drain: got %b want 0", o_vld4); end
  endtask

  initial begin
    test_reset();
    test_max();
    test_signed_min_tie();
    test_back_to_back();
    test_bubble();
    test_reset_midflight();
    test_n4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
